// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display scanner.
package display_pkg;

  localparam int DISP_DIGIT_W     = 4;
  localparam int DISP_REFRESH_DIV = 50000;
  localparam int DISP_MAX_DIGITS  = 16;

  // Counter width for a modulus of n. Never returns less than 1, so a
  // modulus of 1 or 2 still gets a real flop.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot vector with only bit idx set. The caller keeps the bits it needs.
  function automatic logic [DISP_MAX_DIGITS-1:0] onehot_decode(input int unsigned idx);
    return DISP_MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Refresh prescaler: while enabled, pulses tick once every DIV clock cycles.
module refresh_prescaler
  import display_pkg::*;
#(
  parameter int DIV = DISP_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W = clog2_min1(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] pre_cnt_d;

  // Count 0..DIV-1 while enabled; tick in the terminal-count cycle.
  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick      = 1'b0;
    pre_cnt_d = pre_cnt_q;
    if (en) begin
      tick      = (pre_cnt_q == LAST);
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment digit scanner. It has a frame-synchronous
// shadow register, optional leading-zero blanking, a freeze mode and a
// frame-done strobe.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int DIGIT_W        = DISP_DIGIT_W,
  parameter int REFRESH_DIV    = DISP_REFRESH_DIV,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] number,
  input  logic                          freeze,
  input  logic                          force_load,
  input  logic                          blank_lz,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          digit_blank,
  output logic                          frame_done
);

  localparam int               IDX_W    = clog2_min1(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam int               NUM_W    = NUM_DIGITS * DIGIT_W;

  logic             tick;
  logic             wrap;
  logic [IDX_W-1:0] idx_q,        idx_d;
  logic [NUM_W-1:0] shadow_q,     shadow_d;
  logic             frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] sel_onehot;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Next-state logic: advance the scan index and load the shadow at the
  // frame wrap. A force_load loads the same data at any edge. The index is
  // compared with the last digit explicitly, so a non-power-of-2 digit
  // count never reaches an unused index.
  always_comb begin
    wrap         = tick && (idx_q == LAST_IDX);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = wrap;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (force_load) begin
      shadow_d = number;
    end else if (wrap && !freeze) begin
      shadow_d = number;
    end
  end

  // State registers.
  // NOTE: the shadow is an ordinary register and is reset to zero, so after reset no stale digits are shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Leading-zero map: upper_zero[i] is set when shadow digits NUM_DIGITS-1
  // down to i are all zero.
  always_comb begin
    upper_zero = '0;
    all_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero && (shadow_q[i*DIGIT_W +: DIGIT_W] == '0);
      upper_zero[i] = all_zero;
    end
  end

  // Output decode from the registered index and shadow. Disabling the
  // scanner darkens every digit.
  always_comb begin
    sel_onehot  = NUM_DIGITS'(onehot_decode(32'(idx_q)));
    digit_sel   = en ? sel_onehot : '0;
    if (SEL_ACTIVE_LOW) begin
      digit_sel = ~digit_sel;
    end
    digit       = shadow_q[idx_q*DIGIT_W +: DIGIT_W];
    digit_blank = !en || (blank_lz && (idx_q != '0) && upper_zero[idx_q]);
    frame_done  = frame_done_q;
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner. It has two instances: a 4-digit
// /3 scanner and a 6-digit /1 active-low scanner. A reference model predicts
// the outputs after every clock edge and pushes them to queues. A monitor
// pops the queues and compares them one step after each edge.
module tb_display_scanner;

  localparam int N4 = 4;
  localparam int D4 = 3;
  localparam int N6 = 6;
  localparam int D6 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        freeze;
  logic        force_load;
  logic        blank_lz;
  logic [15:0] number;
  logic [23:0] number6;

  logic [3:0] sel4;
  logic [3:0] digit4;
  logic       blank4;
  logic       fd4;
  logic [5:0] sel6;
  logic [3:0] digit6;
  logic       blank6;
  logic       fd6;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: e counts enabled cycles within one frame (0..N*DIV-1).
  typedef struct {
    int          e;
    logic [63:0] shadow;
    logic        fd;
  } mstate_t;

  typedef struct {
    logic [15:0] sel;
    logic [3:0]  digit;
    logic        blank;
    logic        fd;
  } exp_t;

  mstate_t m4 = '{0, 64'd0, 1'b0};
  mstate_t m6 = '{0, 64'd0, 1'b0};
  exp_t    q4[$];
  exp_t    q6[$];

  display_scanner #(
    .NUM_DIGITS     (N4),
    .DIGIT_W        (4),
    .REFRESH_DIV    (D4),
    .SEL_ACTIVE_LOW (1'b0)
  ) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .number      (number),
    .freeze      (freeze),
    .force_load  (force_load),
    .blank_lz    (blank_lz),
    .digit_sel   (sel4),
    .digit       (digit4),
    .digit_blank (blank4),
    .frame_done  (fd4)
  );

  display_scanner #(
    .NUM_DIGITS     (N6),
    .DIGIT_W        (4),
    .REFRESH_DIV    (D6),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut6 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .number      (number6),
    .freeze      (freeze),
    .force_load  (force_load),
    .blank_lz    (blank_lz),
    .digit_sel   (sel6),
    .digit       (digit6),
    .digit_blank (blank6),
    .frame_done  (fd6)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge.
  function automatic mstate_t mstep(mstate_t s, int n, int div, logic rn, logic en_i,
                                    logic fl, logic frz, logic [63:0] num);
    mstate_t r;
    logic    wrap;
    r = s;
    if (!rn) begin
      r.e      = 0;
      r.shadow = 64'd0;
      r.fd     = 1'b0;
      return r;
    end
    wrap = en_i && (s.e == n * div - 1);
    r.fd = wrap;
    if (fl || (wrap && !frz)) r.shadow = num;
    if (en_i) r.e = (s.e + 1) % (n * div);
    return r;
  endfunction

  // Expected outputs for a model state and the current input levels.
  function automatic exp_t model_out(mstate_t s, int n, int div, bit act_low,
                                     logic en_i, logic blz);
    exp_t x;
    int   idx;
    idx     = s.e / div;
    x.sel   = en_i ? (16'd1 << idx) : 16'd0;
    if (act_low) x.sel = ~x.sel & ((16'd1 << n) - 16'd1);
    x.digit = 4'((s.shadow >> (4 * idx)) & 64'hF);
    x.blank = !en_i || (blz && (idx != 0) && ((s.shadow >> (4 * idx)) == 64'd0));
    x.fd    = s.fd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one prediction per edge for each instance.
  always @(posedge clk) begin
    m4 = mstep(m4, N4, D4, rst_n, en, force_load, freeze, 64'(number));
    m6 = mstep(m6, N6, D6, rst_n, en, force_load, freeze, 64'(number6));
    q4.push_back(model_out(m4, N4, D4, 1'b0, en, blank_lz));
    q6.push_back(model_out(m6, N6, D6, 1'b1, en, blank_lz));
  end

  // Monitor: compare outputs shortly after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() == 0) begin
        check("q4_nonempty", 32'd0, 32'd1);
      end else begin
        x = q4.pop_front();
        check("sel4",   32'(sel4),   32'(x.sel[3:0]));
        check("digit4", 32'(digit4), 32'(x.digit));
        check("blank4", 32'(blank4), 32'(x.blank));
        check("fd4",    32'(fd4),    32'(x.fd));
      end
      if (q6.size() == 0) begin
        check("q6_nonempty", 32'd0, 32'd1);
      end else begin
        x = q6.pop_front();
        check("sel6",   32'(sel6),   32'(x.sel[5:0]));
        check("digit6", 32'(digit6), 32'(x.digit));
        check("blank6", 32'(blank6), 32'(x.blank));
        check("fd6",    32'(fd6),    32'(x.fd));
      end
    end
  end

  // Watchdog: the bench must always end.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Wait n edges, then return 2 time units after the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    freeze     = 1'b0;
    force_load = 1'b0;
    blank_lz   = 1'b0;
    number     = 16'h1234;
    number6    = 24'h543210;
    #1;
    check("reset_sel4",   32'(sel4),   32'h1);
    check("reset_sel6",   32'(sel6),   32'h3E);
    check("reset_digit4", 32'(digit4), 32'h0);
    check("reset_fd4",    32'(fd4),    32'h0);
    cycles(1);

    // Release reset with a force_load: the first digit shows 4.
    rst_n      = 1'b1;
    force_load = 1'b1;
    @(posedge clk);
    #1;
    check("first_digit4", 32'(digit4), 32'h4);
    check("first_sel4",   32'(sel4),   32'h1);
    #1;
    force_load = 1'b0;
    cycles(24);

    // A change in mid-frame appears only after the wrap.
    cycles(4);
    number  = 16'hABCD;
    number6 = 24'hFEDCBA;
    cycles(24);

    // Freeze across two wraps, then force a load.
    freeze  = 1'b1;
    number  = 16'h9999;
    number6 = 24'h999999;
    cycles(30);
    force_load = 1'b1;
    cycles(1);
    force_load = 1'b0;
    cycles(5);
    freeze = 1'b0;

    // Leading-zero blanking.
    blank_lz   = 1'b1;
    number     = 16'h0050;
    number6    = 24'h000500;
    force_load = 1'b1;
    cycles(1);
    force_load = 1'b0;
    cycles(12);
    number     = 16'h0000;
    number6    = 24'h000000;
    force_load = 1'b1;
    cycles(1);
    force_load = 1'b0;
    cycles(12);
    blank_lz = 1'b0;
    number   = 16'h1234;

    // Disable at idx 2, pre_cnt 1 for 10 cycles, then resume.
    for (int k = 0; k < 24 && m4.e != 7; k++) cycles(1);
    en = 1'b0;
    cycles(10);
    en = 1'b1;
    cycles(7);

    // Asynchronous reset in mid-frame takes effect immediately.
    rst_n = 1'b0;
    #1;
    check("async_rst_sel4",   32'(sel4),   32'h1);
    check("async_rst_digit4", 32'(digit4), 32'h0);
    check("async_rst_sel6",   32'(sel6),   32'h3E);
    #1;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      en         = ($urandom_range(0, 7) != 0);
      freeze     = ($urandom_range(0, 3) == 0);
      force_load = ($urandom_range(0, 7) == 0);
      blank_lz   = $urandom_range(0, 1) == 1;
      number     = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 16));
      number6    = 24'($urandom >> $urandom_range(8, 32));
      cycles(1);
    end
    rst_n      = 1'b1;
    en         = 1'b1;
    force_load = 1'b0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
